// File: rtl/rom_sweep_checker.sv
// Sweeps a single-port ROM from address 0 to LAST_ADDR, aligns read data to the ROM latency,
// compares each word against an expected pattern and accumulates a mismatch count and checksum.
//
// state | meaning
// IDLE  | out of reset, waiting for start
// SWEEP | issuing one read per cycle unless hold is high
// DRAIN | last read issued, waiting RD_LATENCY cycles for its data
// DONE  | results final, waiting for the next start
module rom_sweep_checker #(
   parameter int unsigned           ADDR_WIDTH    = 16,
   parameter int unsigned           DATA_WIDTH    = 24,
   parameter int unsigned           LAST_ADDR     = 2**ADDR_WIDTH-1,
   parameter int unsigned           RD_LATENCY    = 1,
   parameter int unsigned           CHECK_MODE    = 1,
   parameter logic [DATA_WIDTH-1:0] CONST_VAL     = {DATA_WIDTH{1'b1}},
   parameter int unsigned           ERR_CNT_WIDTH = 8
) (
   input  logic                     clk,
   input  logic                     tb_rst,
   input  logic                     start,
   input  logic                     hold,
   output logic [ADDR_WIDTH-1:0]    rom_addr,
   output logic                     rom_rd_en,
   output logic                     rom_rd_oce,
   input  logic [DATA_WIDTH-1:0]    rom_rd_data,
   output logic                     busy,
   output logic                     done,
   output logic                     pass,
   output logic [ERR_CNT_WIDTH-1:0] err_cnt,
   output logic [ADDR_WIDTH-1:0]    first_err_addr,
   output logic [DATA_WIDTH-1:0]    checksum
);

   typedef enum logic [1:0] {ST_IDLE, ST_SWEEP, ST_DRAIN, ST_DONE} state_t;

   localparam logic [ADDR_WIDTH-1:0] LAST_A     = ADDR_WIDTH'(LAST_ADDR);
   localparam logic [1:0]            DRAIN_LOAD = 2'(RD_LATENCY - 1);

   state_t                               state_q, state_d;
   logic [ADDR_WIDTH-1:0]                rd_addr_q, rd_addr_d;
   logic [RD_LATENCY-1:0]                valid_pipe_q, valid_pipe_d;
   logic [RD_LATENCY-1:0][ADDR_WIDTH-1:0] addr_pipe_q, addr_pipe_d;
   logic [1:0]                           drain_cnt_q, drain_cnt_d;
   logic [ERR_CNT_WIDTH-1:0]             err_cnt_q, err_cnt_d;
   logic [ADDR_WIDTH-1:0]                first_err_addr_q, first_err_addr_d;
   logic                                 first_err_seen_q, first_err_seen_d;
   logic [DATA_WIDTH-1:0]                checksum_q, checksum_d;
   logic                                 done_q, done_d;

   logic                  rd_en;
   logic                  cmp_valid;
   logic [ADDR_WIDTH-1:0] cmp_addr;
   logic [DATA_WIDTH-1:0] exp_addr;
   logic [DATA_WIDTH-1:0] exp_word;
   logic                  mismatch;

   // hold must stall the very cycle it is raised, so read enable is not registered
   assign rd_en     = (state_q == ST_SWEEP) && !hold;
   assign cmp_valid = valid_pipe_q[RD_LATENCY-1];
   assign cmp_addr  = addr_pipe_q[RD_LATENCY-1];

   if (ADDR_WIDTH >= DATA_WIDTH) begin : g_addr_trunc
      assign exp_addr = cmp_addr[DATA_WIDTH-1:0];
   end else begin : g_addr_zext
      assign exp_addr = {{(DATA_WIDTH-ADDR_WIDTH){1'b0}}, cmp_addr};
   end

   assign exp_word = (CHECK_MODE == 1) ? CONST_VAL : exp_addr;
   assign mismatch = (CHECK_MODE != 0) && cmp_valid && (rom_rd_data != exp_word);

   always_comb begin
      state_d          = state_q;
      rd_addr_d        = rd_addr_q;
      valid_pipe_d     = valid_pipe_q;
      addr_pipe_d      = addr_pipe_q;
      drain_cnt_d      = drain_cnt_q;
      err_cnt_d        = err_cnt_q;
      first_err_addr_d = first_err_addr_q;
      first_err_seen_d = first_err_seen_q;
      checksum_d       = checksum_q;
      done_d           = done_q;

      valid_pipe_d[0] = rd_en;
      addr_pipe_d[0]  = rd_addr_q;
      for (int i = 1; i < RD_LATENCY; i++) begin
         valid_pipe_d[i] = valid_pipe_q[i-1];
         addr_pipe_d[i]  = addr_pipe_q[i-1];
      end

      if (cmp_valid) begin
         checksum_d = checksum_q + rom_rd_data;
      end
      if (mismatch) begin
         if (!(&err_cnt_q)) begin
            err_cnt_d = err_cnt_q + ERR_CNT_WIDTH'(1);
         end
         if (!first_err_seen_q) begin
            first_err_addr_d = cmp_addr;
            first_err_seen_d = 1'b1;
         end
      end

      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               state_d          = ST_SWEEP;
               rd_addr_d        = '0;
               err_cnt_d        = '0;
               first_err_addr_d = '0;
               first_err_seen_d = 1'b0;
               checksum_d       = '0;
               done_d           = 1'b0;
            end
         end
         ST_SWEEP: begin
            // the address parks on LAST_ADDR once it has been issued
            if (rd_en) begin
               if (rd_addr_q == LAST_A) begin
                  state_d     = ST_DRAIN;
                  drain_cnt_d = DRAIN_LOAD;
               end else begin
                  rd_addr_d = rd_addr_q + ADDR_WIDTH'(1);
               end
            end
         end
         ST_DRAIN: begin
            if (drain_cnt_q == 2'd0) begin
               state_d = ST_DONE;
               done_d  = 1'b1;
            end else begin
               drain_cnt_d = drain_cnt_q - 2'd1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge tb_rst) begin
      if (tb_rst) begin
         state_q          <= ST_IDLE;
         rd_addr_q        <= '0;
         valid_pipe_q     <= '0;
         addr_pipe_q      <= '0;
         drain_cnt_q      <= '0;
         err_cnt_q        <= '0;
         first_err_addr_q <= '0;
         first_err_seen_q <= 1'b0;
         checksum_q       <= '0;
         done_q           <= 1'b0;
      end else begin
         state_q          <= state_d;
         rd_addr_q        <= rd_addr_d;
         valid_pipe_q     <= valid_pipe_d;
         addr_pipe_q      <= addr_pipe_d;
         drain_cnt_q      <= drain_cnt_d;
         err_cnt_q        <= err_cnt_d;
         first_err_addr_q <= first_err_addr_d;
         first_err_seen_q <= first_err_seen_d;
         checksum_q       <= checksum_d;
         done_q           <= done_d;
      end
   end

   if (RD_LATENCY > 1) begin : g_oce
      assign rom_rd_oce = valid_pipe_q[0];
   end else begin : g_no_oce
      assign rom_rd_oce = 1'b0;
   end

   assign rom_addr       = rd_addr_q;
   assign rom_rd_en      = rd_en;
   assign busy           = (state_q == ST_SWEEP) || (state_q == ST_DRAIN);
   assign done           = done_q;
   assign pass           = done_q && (err_cnt_q == '0);
   assign err_cnt        = err_cnt_q;
   assign first_err_addr = first_err_addr_q;
   assign checksum       = checksum_q;

endmodule

// File: tb/tb_rom_sweep_checker.sv
// Four checker instances (address pattern, constant with output reg, saturating counter,
// single-word checksum-only) swept against behavioural ROMs and a word-list reference model.
module tb_rom_sweep_checker;

   localparam int LASTP [4] = '{15, 15, 15, 0};
   localparam int LATP  [4] = '{1, 2, 1, 2};
   localparam int MODEP [4] = '{2, 1, 1, 0};
   localparam int ECWP  [4] = '{8, 8, 3, 8};

   logic       clk = 1'b0;
   logic       tb_rst;
   logic       start_v [4];
   logic       hold;
   logic [3:0] rom_addr [4];
   logic       rd_en [4];
   logic       oce [4];
   logic [7:0] rdata [4];
   logic       busy [4];
   logic       done [4];
   logic       pass [4];
   logic [7:0] err [4];
   logic [2:0] err_c3;
   logic [3:0] ferr [4];
   logic [7:0] csum [4];

   logic [7:0] mem [4][16];
   logic       hold_sched [200];

   int n_chk = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   rom_sweep_checker #(.ADDR_WIDTH(4), .DATA_WIDTH(8), .LAST_ADDR(15), .RD_LATENCY(1),
                       .CHECK_MODE(2), .CONST_VAL(8'hFF), .ERR_CNT_WIDTH(8)) u_a (
      .clk(clk), .tb_rst(tb_rst), .start(start_v[0]), .hold(hold),
      .rom_addr(rom_addr[0]), .rom_rd_en(rd_en[0]), .rom_rd_oce(oce[0]), .rom_rd_data(rdata[0]),
      .busy(busy[0]), .done(done[0]), .pass(pass[0]), .err_cnt(err[0]),
      .first_err_addr(ferr[0]), .checksum(csum[0]));

   rom_sweep_checker #(.ADDR_WIDTH(4), .DATA_WIDTH(8), .LAST_ADDR(15), .RD_LATENCY(2),
                       .CHECK_MODE(1), .CONST_VAL(8'hFF), .ERR_CNT_WIDTH(8)) u_b (
      .clk(clk), .tb_rst(tb_rst), .start(start_v[1]), .hold(hold),
      .rom_addr(rom_addr[1]), .rom_rd_en(rd_en[1]), .rom_rd_oce(oce[1]), .rom_rd_data(rdata[1]),
      .busy(busy[1]), .done(done[1]), .pass(pass[1]), .err_cnt(err[1]),
      .first_err_addr(ferr[1]), .checksum(csum[1]));

   rom_sweep_checker #(.ADDR_WIDTH(4), .DATA_WIDTH(8), .LAST_ADDR(15), .RD_LATENCY(1),
                       .CHECK_MODE(1), .CONST_VAL(8'hFF), .ERR_CNT_WIDTH(3)) u_c (
      .clk(clk), .tb_rst(tb_rst), .start(start_v[2]), .hold(hold),
      .rom_addr(rom_addr[2]), .rom_rd_en(rd_en[2]), .rom_rd_oce(oce[2]), .rom_rd_data(rdata[2]),
      .busy(busy[2]), .done(done[2]), .pass(pass[2]), .err_cnt(err_c3),
      .first_err_addr(ferr[2]), .checksum(csum[2]));
   assign err[2] = {5'd0, err_c3};

   rom_sweep_checker #(.ADDR_WIDTH(4), .DATA_WIDTH(8), .LAST_ADDR(0), .RD_LATENCY(2),
                       .CHECK_MODE(0), .CONST_VAL(8'hFF), .ERR_CNT_WIDTH(8)) u_d (
      .clk(clk), .tb_rst(tb_rst), .start(start_v[3]), .hold(hold),
      .rom_addr(rom_addr[3]), .rom_rd_en(rd_en[3]), .rom_rd_oce(oce[3]), .rom_rd_data(rdata[3]),
      .busy(busy[3]), .done(done[3]), .pass(pass[3]), .err_cnt(err[3]),
      .first_err_addr(ferr[3]), .checksum(csum[3]));

   // behavioural ROMs: one array register, plus an output register on the latency-2 ones
   for (genvar k = 0; k < 4; k++) begin : g_rom
      logic [7:0] d1, d2;
      always_ff @(posedge clk) begin
         if (rd_en[k]) d1 <= mem[k][rom_addr[k]];
         if (oce[k])   d2 <= d1;
      end
      assign rdata[k] = (k == 1 || k == 3) ? d2 : d1;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_chk++;
      assert (obs === exp_v) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
      end
   endtask

   // expected results straight from the word list and the hold schedule
   task automatic model(input int k, output int e_err, output int e_first,
                        output int e_csum, output int e_done);
      int errs, issued, c, expw, lim;
      errs = 0; e_first = 0; e_csum = 0;
      for (int a = 0; a <= LASTP[k]; a++) begin
         e_csum = (e_csum + int'(mem[k][a])) % 256;
         expw = (MODEP[k] == 1) ? 255 : a;
         if (MODEP[k] != 0 && int'(mem[k][a]) != expw) begin
            if (errs == 0) e_first = a;
            errs++;
         end
      end
      lim = (1 << ECWP[k]) - 1;
      e_err = (errs > lim) ? lim : errs;
      issued = 0; c = 0;
      while (issued <= LASTP[k]) begin
         if (!hold_sched[c]) issued++;
         c++;
      end
      e_done = c + LATP[k] + 1;
   endtask

   task automatic run_sweep(input string name, input logic [3:0] smask, input int mid_start);
      int e_err[4], e_first[4], e_csum[4], e_done[4], got_done[4];
      int issued;
      logic prev_b_en;
      bit all_done;
      for (int k = 0; k < 4; k++) begin
         model(k, e_err[k], e_first[k], e_csum[k], e_done[k]);
         got_done[k] = -1;
      end
      issued = 0;
      prev_b_en = 1'b0;
      @(negedge clk);
      for (int k = 0; k < 4; k++) start_v[k] = smask[k];
      for (int j = 0; j < 200; j++) begin
         @(posedge clk); #1;
         hold = hold_sched[j];
         for (int k = 0; k < 4; k++) start_v[k] = (j == mid_start) && (k != 3);
         #1;
         if (j == 0) chk({name, "_done_cleared"}, done[0], 1'b0);
         for (int k = 0; k < 4; k++)
            if (got_done[k] < 0 && done[k]) got_done[k] = j + 1;
         chk({name, "_a_addr"}, rom_addr[0], (issued < 16) ? issued : 15);
         chk({name, "_a_rd_en"}, rd_en[0], (issued < 16) && !hold_sched[j]);
         if (issued < 16 && !hold_sched[j]) issued++;
         chk({name, "_b_oce"}, oce[1], prev_b_en);
         prev_b_en = rd_en[1];
         all_done = 1'b1;
         for (int k = 0; k < 4; k++) if (got_done[k] < 0) all_done = 1'b0;
         if (all_done) break;
      end
      hold = 1'b0;
      for (int k = 0; k < 4; k++) start_v[k] = 1'b0;
      for (int k = 0; k < 4; k++) begin
         chk($sformatf("%s_done_cycles_%0d", name, k), got_done[k], e_done[k]);
         chk($sformatf("%s_err_cnt_%0d", name, k), err[k], e_err[k]);
         chk($sformatf("%s_first_err_%0d", name, k), ferr[k], e_first[k]);
         chk($sformatf("%s_checksum_%0d", name, k), csum[k], e_csum[k]);
         chk($sformatf("%s_pass_%0d", name, k), pass[k], (got_done[k] >= 0) && e_err[k] == 0);
         chk($sformatf("%s_busy_%0d", name, k), busy[k], 1'b0);
         chk($sformatf("%s_addr_park_%0d", name, k), rom_addr[k], LASTP[k]);
      end
   endtask

   initial begin
      tb_rst = 1'b1;
      hold = 1'b0;
      for (int k = 0; k < 4; k++) start_v[k] = 1'b0;
      for (int j = 0; j < 200; j++) hold_sched[j] = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_addr", rom_addr[0], 0);
      chk("rst_busy", busy[0], 0);
      chk("rst_done", done[2], 0);
      chk("rst_csum", csum[1], 0);
      @(negedge clk);
      tb_rst = 1'b0;

      // baseline words: address pattern, all 0xFF, all 0x00, random single word
      for (int a = 0; a < 16; a++) begin
         mem[0][a] = 8'(a);
         mem[1][a] = 8'hFF;
         mem[2][a] = 8'h00;
         mem[3][a] = 8'($urandom_range(0, 255));
      end
      run_sweep("base", 4'hF, -1);

      // two corrupted words, three-cycle hold at address 6, ignored start while busy
      mem[0][5] = 8'hFF;
      mem[0][9] = 8'h09 ^ 8'($urandom_range(1, 255));
      for (int a = 0; a < 16; a++) begin
         mem[1][a] = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'hFF;
         mem[2][a] = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 255)) : 8'hFF;
      end
      mem[3][0] = 8'($urandom_range(0, 255));
      hold_sched[6] = 1'b1; hold_sched[7] = 1'b1; hold_sched[8] = 1'b1;
      run_sweep("hold", 4'hF, 10);

      for (int s = 0; s < 4; s++) begin
         for (int a = 0; a < 16; a++) begin
            mem[0][a] = ($urandom_range(0, 4) == 0) ? 8'($urandom_range(0, 255)) : 8'(a);
            mem[1][a] = ($urandom_range(0, 4) == 0) ? 8'($urandom_range(0, 255)) : 8'hFF;
            mem[2][a] = ($urandom_range(0, 6) == 0) ? 8'($urandom_range(0, 255)) : 8'hFF;
            mem[3][a] = 8'($urandom_range(0, 255));
         end
         for (int j = 0; j < 200; j++) hold_sched[j] = (j < 40) && ($urandom_range(0, 3) == 0);
         run_sweep($sformatf("rand%0d", s), 4'hF, -1);
      end

      // reset in the middle of a sweep
      for (int j = 0; j < 200; j++) hold_sched[j] = 1'b0;
      for (int a = 0; a < 16; a++) mem[0][a] = 8'(a);
      mem[0][3] = 8'hAA;
      @(negedge clk);
      for (int k = 0; k < 4; k++) start_v[k] = 1'b1;
      @(posedge clk); #1;
      for (int k = 0; k < 4; k++) start_v[k] = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      chk("pre_rst_addr", rom_addr[0], 10);
      chk("pre_rst_err", err[0], 1);
      tb_rst = 1'b1;
      #1;
      chk("mid_rst_addr", rom_addr[0], 0);
      chk("mid_rst_rd_en", rd_en[0], 0);
      chk("mid_rst_busy", busy[0], 0);
      chk("mid_rst_err", err[0], 0);
      chk("mid_rst_first", ferr[0], 0);
      chk("mid_rst_csum", csum[0], 0);
      chk("mid_rst_oce", oce[1], 0);
      repeat (2) @(posedge clk);
      #1;
      chk("mid_rst_no_compare", csum[0], 0);
      @(negedge clk);
      tb_rst = 1'b0;
      mem[0][3] = 8'h03;
      run_sweep("post_rst", 4'hF, -1);

      // start coincident with reset: reset wins
      @(negedge clk);
      tb_rst = 1'b1;
      for (int k = 0; k < 4; k++) start_v[k] = 1'b1;
      @(posedge clk); #1;
      chk("rst_start_busy", busy[0], 0);
      @(negedge clk);
      tb_rst = 1'b0;
      for (int k = 0; k < 4; k++) start_v[k] = 1'b0;
      @(posedge clk); #1;
      chk("rst_start_idle", busy[0], 0);
      chk("rst_start_done", done[0], 0);
      chk("rst_start_rd_en", rd_en[1], 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/rom_sweep_checker.md
Name: rom_sweep_checker

Overview:
- Parametrised, self-checking sweep engine for single-port ROM instances, e.g. the 24-bit image ROMs preloaded from .dat files.
- Drives a ROM's address, read-enable and output-clock-enable, and aligns returned data to the ROM's read latency.
- Compares each word against a selectable expected pattern, counts mismatches and accumulates a checksum.
- Used in simulation benches and as on-chip BIST ahead of the image filter pipeline.

Parameters:
- ADDR_WIDTH, 16, ROM address width.
- DATA_WIDTH, 24, ROM data width.
- LAST_ADDR, 2**ADDR_WIDTH-1, final address swept (inclusive).
- RD_LATENCY, 1, ROM read latency in cycles; legal 1 (no output reg) or 2 (output reg).
- CHECK_MODE, 1, expected-data mode: 0 = checksum only, no compare; 1 = constant CONST_VAL; 2 = address pattern.
- CONST_VAL, {DATA_WIDTH{1'b1}}, expected word in mode 1.
- ERR_CNT_WIDTH, 8, error counter width.

Ports:
- clk  in  1  clock; all logic on rising edge.
- tb_rst  in  1  reset, asynchronous, active-high.
- start  in  1  single-cycle pulse; begins a sweep.
- hold  in  1  stalls address issue while high.
- rom_addr  out  ADDR_WIDTH  ROM address.
- rom_rd_en  out  1  ROM read enable.
- rom_rd_oce  out  1  ROM output-register clock enable; tied 0 when RD_LATENCY=1.
- rom_rd_data  in  DATA_WIDTH  ROM read data.
- busy  out  1  high in SWEEP and DRAIN.
- done  out  1  sweep complete; sticky until next accepted start.
- pass  out  1  done & (err_cnt==0).
- err_cnt  out  ERR_CNT_WIDTH  mismatch count; saturating.
- first_err_addr  out  ADDR_WIDTH  address of the first mismatch.
- checksum  out  DATA_WIDTH  sum of all valid read words, mod 2^DATA_WIDTH.

Behaviour:
- Reset clears every output and all internal state to 0, and places the FSM in IDLE.
  - Applies mid-sweep too: the pipeline is flushed and no further compares occur.
- FSM states: IDLE, SWEEP, DRAIN, DONE.
- IDLE/DONE -> SWEEP on start.
  - Same edge clears err_cnt, first_err_addr, checksum, done and the first-error flag.
  - start is ignored while busy.
- SWEEP, hold=0:
  - rom_rd_en=1 with rom_addr = current address; address increments by 1 next cycle.
  - Issuing LAST_ADDR moves the FSM to DRAIN next cycle.
- SWEEP, hold=1:
  - rom_rd_en=0 and rom_addr holds.
  - Reads already issued keep moving through the latency pipe.
- DRAIN:
  - rom_rd_en=0.
  - Lasts exactly RD_LATENCY cycles, then DONE; done=1 on DONE entry.
- rom_addr after the sweep holds LAST_ADDR; it returns to 0 on the next start.
- Latency pipe:
  - rom_rd_en and rom_addr are delayed RD_LATENCY stages, giving valid_q and addr_q.
  - rom_rd_data is sampled on a cycle where valid_q=1.
  - When RD_LATENCY=2, rom_rd_oce = first-stage delayed rd_en.
- Expected word:
  - Mode 1: CONST_VAL.
  - Mode 2: addr_q zero-extended, or truncated to the low DATA_WIDTH bits if ADDR_WIDTH > DATA_WIDTH.
- Compare, on a valid_q cycle:
  - Mismatch (modes 1/2 only) increments err_cnt, saturating at all-ones.
  - The first mismatch of a sweep latches addr_q into first_err_addr; later mismatches do not change it.
  - Mode 0 never flags errors.
- Checksum: checksum += rom_rd_data on every valid_q cycle, in all modes; wraps modulo 2^DATA_WIDTH.
- Total words checked = LAST_ADDR+1, independent of hold pattern.
- Sweep length with no hold: start edge to done=1 is LAST_ADDR+1+RD_LATENCY+1 cycles.
- LAST_ADDR=0 is legal: one read, then DRAIN.
- start in the same cycle as tb_rst: reset wins.

Test Plan:
- ADDR_WIDTH=4, DATA_WIDTH=8, CHECK_MODE=2, RD_LATENCY=1, ROM model returning its address -> done after 18 cycles, err_cnt=0, pass=1, checksum=0x78.
- Same setup, ROM corrupts addr 5 (0xFF) and addr 9 -> err_cnt=2, first_err_addr=5, pass=0, checksum=0x78-5+0xFF-9+corrupt9 mod 256.
- CHECK_MODE=1, CONST_VAL=0xFF, RD_LATENCY=2, all words 0xFF -> rom_rd_oce trails rom_rd_en by 1 cycle, pass=1, checksum=0xF0, done 19 cycles after start.
- ERR_CNT_WIDTH=3, mode 1, all words 0x00 -> err_cnt saturates at 7, first_err_addr=0.
- hold high for 3 cycles at addr 6 and a start pulse mid-sweep -> rom_addr stays 6, start ignored, 16 words checked, done 3 cycles later than baseline.
- tb_rst asserted at addr 10 -> all outputs 0 immediately; new start gives a clean full sweep with pass=1.
